button_debouncer: RTL and testbench

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

---
 rtl/button_debouncer.sv | 179 +++++++++++++++++
 tb/tb_button_debouncer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// ============================================================================
// Module   : button_debouncer
// Purpose  : Push-button synchronizer and debouncer with optional auto-repeat
//            strobe (enabled by defining BUTTON_DEBOUNCER_AUTOREPEAT_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 20000000
) (
    input  logic clk,
    input  logic reset,
    input  logic button_in,
    output logic button_clean,
    output logic repeat_tick
);

    localparam int MAX_DR  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_ALL = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
    localparam int CNT_W   = $clog2(MAX_ALL);

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // The sample that leaves a STABLE state is the first qualifying one, so the
    // WAIT counter only has to see DEBOUNCE_CYCLES-1 further samples.
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 2);

    localparam logic [1:0] S_STABLE_LOW  = 2'd0;
    localparam logic [1:0] S_WAIT_HIGH   = 2'd1;
    localparam logic [1:0] S_STABLE_HIGH = 2'd2;
    localparam logic [1:0] S_WAIT_LOW    = 2'd3;

    logic             sync1_q;
    logic             sync2_q;
    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] db_cnt_q;
    logic [CNT_W-1:0] db_cnt_d;
    logic             clean_q;
    logic             clean_d;
    logic             w_accept_high;
    logic             w_accept_low;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= button_in;
            sync2_q <= sync1_q;
        end
    end

    assign w_accept_high = (state_q == S_WAIT_HIGH) && sync2_q  && (db_cnt_q == DB_LAST);
    assign w_accept_low  = (state_q == S_WAIT_LOW)  && !sync2_q && (db_cnt_q == DB_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_STABLE_LOW;
            db_cnt_q <= CNT_ZERO;
            clean_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            db_cnt_q <= db_cnt_d;
            clean_q  <= clean_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        db_cnt_d = db_cnt_q;
        case (state_q)
            S_STABLE_LOW: begin
                db_cnt_d = CNT_ZERO;
                if (sync2_q) begin
                    state_d = S_WAIT_HIGH;
                end
            end
            S_WAIT_HIGH: begin
                if (!sync2_q) begin
                    state_d  = S_STABLE_LOW;
                    db_cnt_d = CNT_ZERO;
                end else if (w_accept_high) begin
                    state_d  = S_STABLE_HIGH;
                    db_cnt_d = CNT_ZERO;
                end else begin
                    db_cnt_d = db_cnt_q + CNT_ONE;
                end
            end
            S_STABLE_HIGH: begin
                db_cnt_d = CNT_ZERO;
                if (!sync2_q) begin
                    state_d = S_WAIT_LOW;
                end
            end
            S_WAIT_LOW: begin
                if (sync2_q) begin
                    state_d  = S_STABLE_HIGH;
                    db_cnt_d = CNT_ZERO;
                end else if (w_accept_low) begin
                    state_d  = S_STABLE_LOW;
                    db_cnt_d = CNT_ZERO;
                end else begin
                    db_cnt_d = db_cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d  = S_STABLE_LOW;
                db_cnt_d = CNT_ZERO;
            end
        endcase
    end

    always_comb begin
        clean_d = clean_q;
        if (w_accept_high) begin
            clean_d = 1'b1;
        end else if (w_accept_low) begin
            clean_d = 1'b0;
        end
    end

    assign button_clean = clean_q;

`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] rep_cnt_q;
    logic [CNT_W-1:0] rep_cnt_d;
    logic             rep_first_q;
    logic             rep_first_d;
    logic             tick_q;
    logic             tick_d;
    logic             w_rep_hit;

    // Keyed on the accepted level only, so a rejected release bounce
    // leaves the repeat schedule running.
    assign w_rep_hit = rep_first_q ? (rep_cnt_q == RP_LAST) : (rep_cnt_q == RD_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rep_cnt_q   <= CNT_ZERO;
            rep_first_q <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
            tick_q      <= tick_d;
        end
    end

    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
        tick_d      = 1'b0;
        if (!clean_q || w_accept_low) begin
            rep_cnt_d   = CNT_ZERO;
            rep_first_d = 1'b0;
        end else if (w_rep_hit) begin
            rep_cnt_d   = CNT_ZERO;
            rep_first_d = 1'b1;
            tick_d      = 1'b1;
        end else begin
            rep_cnt_d = rep_cnt_q + CNT_ONE;
        end
    end

    assign repeat_tick = tick_q;
`else
    assign repeat_tick = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_button_debouncer.sv
// ============================================================================
// Module   : tb_button_debouncer
// Purpose  : Randomized scoreboard bench for button_debouncer against a
//            run-length / schedule reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_button_debouncer;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 5;

    logic clk       = 1'b0;
    logic reset     = 1'b1;
    logic button_in = 1'b0;
    logic button_clean;
    logic repeat_tick;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int   cyc;
        logic clean;
        logic tick;
    } ev_t;

    ev_t exp_q[$];

    button_debouncer #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .button_in    (button_in),
        .button_clean (button_clean),
        .repeat_tick  (repeat_tick)
    );

    always #5 clk = ~clk;

    // Reference model: level flips once DB consecutive synchronized samples
    // disagree with it; ticks fall on a fixed schedule measured from the rise.
    int   cyc     = 0;
    logic m_p1    = 1'b0;
    logic m_p2    = 1'b0;
    int   m_run   = 0;
    logic m_clean = 1'b0;
    int   m_rise  = 0;

    always @(posedge clk) begin : model
        logic samp;
        logic prev;
        logic tk;
        int   k;
        cyc  = cyc + 1;
        prev = m_clean;
        tk   = 1'b0;
        k    = 0;
        if (!reset) begin
            m_p1    = 1'b0;
            m_p2    = 1'b0;
            m_run   = 0;
            m_clean = 1'b0;
        end else begin
            samp = m_p2;
            m_p2 = m_p1;
            m_p1 = button_in;
            if (samp != m_clean) m_run = m_run + 1;
            else                 m_run = 0;
            if (m_run == DB) begin
                m_clean = ~m_clean;
                m_run   = 0;
                if (m_clean) m_rise = cyc;
            end
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
            if (m_clean && prev) begin
                k  = cyc - m_rise;
                tk = (k >= RD) && (((k - RD) % RP) == 0);
            end
`endif
        end
        if ((m_clean != prev) || tk) exp_q.push_back('{cyc, m_clean, tk});
    end

    logic mon_prev = 1'b0;

    always @(posedge clk) begin : monitor
        ev_t e;
        #1;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            checks   = checks + 1;
            failures = failures + 1;
            $display("FAIL missed_event: expected clean=%b tick=%b at cycle %0d, DUT showed nothing", e.clean, e.tick, e.cyc);
        end
        if ((button_clean !== mon_prev) || (repeat_tick !== 1'b0)) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                failures = failures + 1;
                $display("FAIL unexpected_event: cycle %0d DUT clean=%b tick=%b, expected no event", cyc, button_clean, repeat_tick);
            end else begin
                e = exp_q.pop_front();
                if ((e.cyc != cyc) || (e.clean !== button_clean) || (e.tick !== repeat_tick)) begin
                    failures = failures + 1;
                    $display("FAIL event: DUT cycle=%0d clean=%b tick=%b, expected cycle=%0d clean=%b tick=%b",
                             cyc, button_clean, repeat_tick, e.cyc, e.clean, e.tick);
                end
            end
        end
        mon_prev = button_clean;
    end

    task automatic chk(input string name, input logic act, input logic exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic hold(input logic lvl, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            button_in = lvl;
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_clean", button_clean, 1'b0);
        chk("async_reset_tick", repeat_tick, 1'b0);
        @(posedge clk);
        #2 reset = 1'b1;
    endtask

    initial begin : stimulus
        logic lvl;
        int   len;
        #2 reset = 1'b0;
        #1;
        chk("reset_clean", button_clean, 1'b0);
        chk("reset_tick", repeat_tick, 1'b0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        hold(1'b0, 5);

        // clean press / release
        hold(1'b1, 20);
        hold(1'b0, 12);
        // press bounce, then short release glitch
        hold(1'b1, 3);
        hold(1'b0, 1);
        hold(1'b1, 12);
        hold(1'b0, 2);
        hold(1'b1, 10);
        hold(1'b0, 12);
        // long hold for auto-repeat
        hold(1'b1, 50);
        hold(1'b0, 10);
        // reset inside the press qualification window
        hold(1'b1, 3);
        pulse_reset();
        hold(1'b1, 30);
        hold(1'b0, 10);
        // reset while repeating
        hold(1'b1, 20);
        pulse_reset();
        hold(1'b1, 30);
        hold(1'b0, 10);

        for (int s = 0; s < 250; s++) begin
            lvl = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(5, 30)) : int'($urandom_range(1, 6));
            hold(lvl, len);
            if ($urandom_range(0, 30) == 0) pulse_reset();
        end
        hold(1'b0, 20);
        repeat (3) @(posedge clk);
        #2;
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL drain: %0d expected events left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
